// File: rtl/nivel_cxa_cond.sv
// Tank float-switch conditioner: 2-flop sync, per-bit debounce, thermometer-code legality check
// with sticky sensor fault, and an inlet-valve FSM with fill timeout. Outputs are registered.
module nivel_cxa_cond #(
  parameter logic [15:0] DB_CYCLES  = 16'd50000,
  parameter logic [15:0] ERR_CYCLES = 16'd60000,
  parameter logic [31:0] FILL_TMO   = 32'd3000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_low,
  input  logic sw_mid,
  input  logic sw_high,
  input  logic fill_en,
  input  logic err_clr,
  output logic Nv2,
  output logic Nv1,
  output logic Nv0,
  output logic sensor_err,
  output logic valve_open,
  output logic fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [2:0]        sync1_q, sync2_q;
  logic [2:0]        db_q, db_d;
  logic [2:0][15:0]  db_cnt_q, db_cnt_d;
  logic [2:0]        nv_q, nv_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              sensor_err_q, sensor_err_d;
  logic [1:0]        state_q, state_d;
  logic [31:0]       fill_tmr_q, fill_tmr_d;
  logic              valve_q, valve_d;
  logic              fault_q, fault_d;
  logic              legal;
  logic              err_clearing;

  // Bit order everywhere is {high, mid, low}.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_CYCLES - 16'd1) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  assign legal = (db_q == 3'b000) || (db_q == 3'b001) ||
                 (db_q == 3'b011) || (db_q == 3'b111);
  assign err_clearing = err_clr && legal;

  always_comb begin
    nv_d         = nv_q;
    err_cnt_d    = err_cnt_q;
    sensor_err_d = sensor_err_q;
    if (legal) begin
      nv_d      = db_q;
      err_cnt_d = '0;
      if (err_clr) sensor_err_d = 1'b0;
    end else begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == ERR_CYCLES - 16'd1) sensor_err_d = 1'b1;
    end
  end

  // FAULT may be left in the same cycle sensor_err is cleared; elsewhere sensor_err forces FAULT.
  always_comb begin
    state_d    = state_q;
    fill_tmr_d = fill_tmr_q;
    case (state_q)
      S_IDLE: begin
        if (sensor_err_q) begin
          state_d = S_FAULT;
        end else if (fill_en && (nv_q == 3'b000)) begin
          state_d    = S_FILL;
          fill_tmr_d = '0;
        end
      end
      S_FILL: begin
        if (sensor_err_q) begin
          state_d = S_FAULT;
        end else if (nv_q[2] || !fill_en) begin
          state_d = S_IDLE;
        end else if (fill_tmr_q == FILL_TMO - 32'd1) begin
          state_d = S_FAULT;
        end else begin
          fill_tmr_d = fill_tmr_q + 32'd1;
        end
      end
      S_FAULT: begin
        if (err_clr && (!sensor_err_q || err_clearing)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valve_d = (state_d == S_FILL);
  assign fault_d = (state_d == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_cnt_q     <= '0;
      nv_q         <= '0;
      err_cnt_q    <= '0;
      sensor_err_q <= 1'b0;
      state_q      <= S_IDLE;
      fill_tmr_q   <= '0;
      valve_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      sync1_q      <= {sw_high, sw_mid, sw_low};
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      nv_q         <= nv_d;
      err_cnt_q    <= err_cnt_d;
      sensor_err_q <= sensor_err_d;
      state_q      <= state_d;
      fill_tmr_q   <= fill_tmr_d;
      valve_q      <= valve_d;
      fault_q      <= fault_d;
    end
  end

  assign Nv2        = nv_q[2];
  assign Nv1        = nv_q[1];
  assign Nv0        = nv_q[0];
  assign sensor_err = sensor_err_q;
  assign valve_open = valve_q;
  assign fault      = fault_q;

endmodule
